// File: rtl/ppm_frame_ctrl.sv
// Frame sequencer for the 2-bit PPM shifter: reads frame bytes from a sync-read buffer
// and strobes them into the shifter back-to-back, keyed off the shifter's early done.
module ppm_frame_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] frame_len,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        byte_out,
    output logic              byte_strobe,
    input  logic              send_done_in,
    input  logic              sym_active,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned PIPE_W  = MEM_LAT;
    localparam int unsigned DRAIN_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FIRST_RD = 2'd1,
        STREAM   = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   rem_q, rem_d;
    logic [PIPE_W-1:0]   pipe_q, pipe_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic                done_q, done_d;
    logic                rd_en_c;
    logic                flush_c;

    // Next-state, read issue and pipe update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        drain_d = drain_q;
        done_d  = 1'b0;
        rd_en_c = 1'b0;
        flush_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !sym_active) begin
                    if (frame_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        rem_d   = frame_len - ADDR_W'(1);
                        addr_d  = '0;
                        state_d = FIRST_RD;
                    end
                end
            end
            FIRST_RD: begin
                rd_en_c = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = STREAM;
            end
            STREAM: begin
                // Early done gives exactly the read latency, so the strobe meets count 127
                if (send_done_in) begin
                    if (rem_q != '0) begin
                        rd_en_c = 1'b1;
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - ADDR_W'(1);
                    end else begin
                        drain_d = '0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything and kills reads still in flight
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            addr_d  = addr_q;
            rem_d   = rem_q;
            done_d  = 1'b0;
            rd_en_c = 1'b0;
            flush_c = 1'b1;
        end

        pipe_d = flush_c ? '0 : PIPE_W'({pipe_q, rd_en_c});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pipe_q  <= '0;
            drain_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pipe_q  <= pipe_d;
            drain_q <= drain_d;
            done_q  <= done_d;
        end
    end

    assign mem_rd_en   = rd_en_c;
    assign mem_addr    = addr_q;
    assign byte_out    = mem_rdata;
    assign byte_strobe = pipe_q[PIPE_W-1];
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
// Bench for ppm_frame_ctrl: sync-read buffer and PPM shifter models, with expected
// read/strobe/done timing derived from the byte period of the shifter.
module tb_ppm_frame_ctrl;

    localparam int unsigned ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] frame_len = '0;
    logic              abort = 1'b0;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [7:0]        byte_out;
    logic              byte_strobe;
    logic              send_done_in;
    logic              sym_active;
    logic              busy;
    logic              frame_done;

    ppm_frame_ctrl #(.ADDR_W(ADDR_W), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len), .abort(abort),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .byte_out(byte_out), .byte_strobe(byte_strobe), .send_done_in(send_done_in),
        .sym_active(sym_active), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame buffer: two-cycle synchronous read
    logic [7:0] mem [256];
    logic [7:0] rd_s1;
    always @(posedge clk) begin
        rd_s1     <= mem_rd_en ? mem[mem_addr] : 8'hxx;
        mem_rdata <= rd_s1;
    end

    // Shifter: 4 symbols of (sym_last+1) cycles per byte, done at count sym_last-2 of symbol 3
    int       sym_last = 127;
    logic     sh_act = 1'b0;
    int       sh_cnt = 0;
    int       sh_sym = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_act <= 1'b0; sh_cnt <= 0; sh_sym <= 0;
        end else if (!sh_act) begin
            if (byte_strobe) begin sh_act <= 1'b1; sh_cnt <= 0; sh_sym <= 0; end
        end else if (sh_cnt == sym_last) begin
            sh_cnt <= 0;
            if (sh_sym == 3) begin
                if (byte_strobe) sh_sym <= 0;
                else sh_act <= 1'b0;
            end else begin
                sh_sym <= sh_sym + 1;
            end
        end else begin
            sh_cnt <= sh_cnt + 1;
        end
    end
    assign sym_active   = sh_act;
    assign send_done_in = sh_act && (sh_sym == 3) && (sh_cnt == sym_last - 2);

    // Event log sampled away from the active edge
    int rd_cyc[$];
    int rd_addr[$];
    int st_cyc[$];
    int st_byte[$];
    int done_cyc[$];
    int done_busy[$];
    int gap_cnt = 0;
    bit seen = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) begin rd_cyc.push_back(cyc); rd_addr.push_back(int'(mem_addr)); end
            if (byte_strobe) begin st_cyc.push_back(cyc); st_byte.push_back(int'(byte_out)); end
            if (frame_done) begin done_cyc.push_back(cyc); done_busy.push_back(int'(busy)); end
            if (!busy) seen = 1'b0;
            else if (byte_strobe) seen = 1'b1;
            else if (seen && !sym_active) gap_cnt++;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int budget = 2000;
        while ((sym_active || busy) && budget > 0) begin tick(1); budget--; end
        chk("idle_timeout", 32'(budget > 0), 32'd1);
    endtask

    task automatic fill_rand(input int len);
        for (int i = 0; i < len; i++) mem[i] = 8'($urandom);
    endtask

    // Runs one full frame from an idle shifter and checks against the period model
    task automatic run_frame(input string tag, input int len);
        int p, t0, rb, sb, db, gb, budget;
        p  = 4 * (sym_last + 1);
        rb = rd_cyc.size(); sb = st_cyc.size(); db = done_cyc.size(); gb = gap_cnt;
        t0 = cyc;
        start = 1'b1; frame_len = ADDR_W'(len);
        tick(1);
        start = 1'b0;
        budget = p * (len + 1) + 50;
        while (done_cyc.size() == db && budget > 0) begin tick(1); budget--; end
        chk({tag, "_done_timeout"}, 32'(budget > 0), 32'd1);
        tick(3);
        chk({tag, "_rd_count"}, 32'(rd_cyc.size() - rb), 32'(len));
        chk({tag, "_strobe_count"}, 32'(st_cyc.size() - sb), 32'(len));
        for (int i = 0; i < len; i++) begin
            if (rb + i < rd_cyc.size()) begin
                chk({tag, "_rd_addr"}, 32'(rd_addr[rb + i]), 32'(i));
                chk({tag, "_rd_cyc"}, 32'(rd_cyc[rb + i]), 32'(t0 + 1 + p * i));
            end
            if (sb + i < st_cyc.size()) begin
                chk({tag, "_strobe_byte"}, 32'(st_byte[sb + i]), 32'(mem[i]));
                chk({tag, "_strobe_cyc"}, 32'(st_cyc[sb + i]), 32'(t0 + 3 + p * i));
            end
        end
        chk({tag, "_done_count"}, 32'(done_cyc.size() - db), 32'd1);
        if (done_cyc.size() > db) begin
            chk({tag, "_done_cyc"}, 32'(done_cyc[db]), 32'(t0 + 3 + p * len + 1));
            chk({tag, "_done_busy"}, 32'(done_busy[db]), 32'd0);
        end
        chk({tag, "_sym_gap"}, 32'(gap_cnt - gb), 32'd0);
    endtask

    initial begin
        int rb, sb, db, budget, t0, len;

        // Reset state
        tick(3);
        chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_strobe", 32'(byte_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single byte
        mem[0] = 8'hA5;
        run_frame("t1", 1);

        // Four bytes back-to-back
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        run_frame("t2", 4);

        // Zero-length frame
        rb = rd_cyc.size(); sb = st_cyc.size(); db = done_cyc.size();
        start = 1'b1; frame_len = '0;
        tick(1);
        start = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(frame_done), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        tick(5);
        chk("t3_rd_count", 32'(rd_cyc.size() - rb), 32'd0);
        chk("t3_strobe_count", 32'(st_cyc.size() - sb), 32'd0);
        chk("t3_done_count", 32'(done_cyc.size() - db), 32'd1);

        // Abort after second strobe; start held off until the shifter goes idle
        fill_rand(5);
        rb = rd_cyc.size(); sb = st_cyc.size(); db = done_cyc.size();
        start = 1'b1; frame_len = ADDR_W'(5);
        tick(1);
        start = 1'b0;
        budget = 2000;
        while (st_cyc.size() - sb < 2 && budget > 0) begin tick(1); budget--; end
        chk("t4_strobe_timeout", 32'(budget > 0), 32'd1);
        tick(20);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b1; frame_len = ADDR_W'(2);
        @(negedge clk);
        chk("t4_busy_after_abort", 32'(busy), 32'd0);
        chk("t4_shifter_still_active", 32'(sym_active), 32'd1);
        tick(1);
        start = 1'b0;
        @(negedge clk);
        chk("t4_start_ignored", 32'(busy), 32'd0);
        wait_idle();
        tick(3);
        chk("t4_rd_count", 32'(rd_cyc.size() - rb), 32'd2);
        chk("t4_strobe_count", 32'(st_cyc.size() - sb), 32'd2);
        chk("t4_no_done", 32'(done_cyc.size() - db), 32'd0);
        fill_rand(2);
        run_frame("t4_restart", 2);

        // Abort with a read in flight: its strobe must never appear
        fill_rand(3);
        rb = rd_cyc.size(); sb = st_cyc.size(); db = done_cyc.size();
        start = 1'b1; frame_len = ADDR_W'(3);
        tick(1);
        start = 1'b0;
        budget = 2000;
        @(negedge clk);
        while (!send_done_in && budget > 0) begin @(negedge clk); budget--; end
        chk("inflight_timeout", 32'(budget > 0), 32'd1);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_idle();
        tick(3);
        chk("inflight_rd_count", 32'(rd_cyc.size() - rb), 32'd2);
        chk("inflight_strobe_count", 32'(st_cyc.size() - sb), 32'd1);
        chk("inflight_no_done", 32'(done_cyc.size() - db), 32'd0);

        // Start during STREAM ignored, then asynchronous reset mid-frame
        fill_rand(4);
        rb = rd_cyc.size(); sb = st_cyc.size(); db = done_cyc.size();
        start = 1'b1; frame_len = ADDR_W'(4);
        tick(1);
        start = 1'b0;
        tick(60);
        start = 1'b1; frame_len = ADDR_W'(7);
        tick(1);
        start = 1'b0;
        budget = 2000;
        while (st_cyc.size() - sb < 2 && budget > 0) begin tick(1); budget--; end
        chk("t5_strobe_timeout", 32'(budget > 0), 32'd1);
        tick(20);
        chk("t5_rd_count", 32'(rd_cyc.size() - rb), 32'd2);
        if (rd_cyc.size() - rb >= 2) chk("t5_rd_addr1", 32'(rd_addr[rb + 1]), 32'd1);
        chk("t5_busy_before_rst", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_rd_en", 32'(mem_rd_en), 32'd0);
        chk("t5_rst_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_strobe", 32'(byte_strobe), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_done", 32'(frame_done), 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("t5_no_done", 32'(done_cyc.size() - db), 32'd0);

        // Randomized frames at full and shortened symbol periods
        for (int k = 0; k < 2; k++) begin
            len = $urandom_range(2, 5);
            fill_rand(len);
            run_frame("rand_slow", len);
        end
        for (int k = 0; k < 3; k++) begin
            sym_last = $urandom_range(4, 15);
            len = $urandom_range(1, 20);
            fill_rand(len);
            run_frame("rand_fast", len);
        end

        // Maximum frame length
        sym_last = 7;
        fill_rand(255);
        run_frame("t6", 255);
        t0 = cyc;
        chk("t6_end_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
